// File: rtl/hamming_byte_assembler.sv
// Pairs corrected Hamming(7,4) nibbles into bytes on a valid/ready output.
// It flags bytes that contained a corrected bit and keeps a saturating count of corrected nibbles.
module hamming_byte_assembler #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_w,
    input  logic [2:0]       in_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_byte,
    output logic             out_err,
    input  logic             clr_count,
    output logic [CNT_W-1:0] err_count
);

    // Handshake: a transfer happens on a rising clk edge where valid && ready;
    // valid never waits on ready, and the output holds while out_valid && !out_ready.
    typedef enum logic {
        ST_HI = 1'b0,
        ST_LO = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         hi_nib_q, hi_nib_d;
    logic               hi_err_q, hi_err_d;
    logic               out_valid_q, out_valid_d;
    logic [7:0]         out_byte_q, out_byte_d;
    logic               out_err_q, out_err_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;
    logic               in_fire;
    logic               out_fire;
    logic               nib_err;

    always_comb begin
        state_d     = state_q;
        hi_nib_d    = hi_nib_q;
        hi_err_d    = hi_err_q;
        out_valid_d = out_valid_q;
        out_byte_d  = out_byte_q;
        out_err_d   = out_err_q;
        err_count_d = err_count_q;

        // The first nibble never touches the output slot, so it is always accepted.
        in_ready = (state_q == ST_HI) || !out_valid_q || out_ready;
        in_fire  = in_valid && in_ready;
        out_fire = out_valid_q && out_ready;
        nib_err  = (in_s != 3'b000);

        if (out_fire) begin
            out_valid_d = 1'b0;
        end

        if (in_fire) begin
            if (state_q == ST_HI) begin
                hi_nib_d = in_w;
                hi_err_d = nib_err;
                state_d  = ST_LO;
            end else begin
                out_byte_d  = {hi_nib_q, in_w};
                out_err_d   = hi_err_q || nib_err;
                out_valid_d = 1'b1;
                state_d     = ST_HI;
            end
        end

        // Clear wins over a same-cycle increment; the counter sticks at all-ones.
        if (clr_count) begin
            err_count_d = '0;
        end else if (in_fire && nib_err && (err_count_q != {CNT_W{1'b1}})) begin
            err_count_d = err_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_HI;
            hi_nib_q    <= 4'h0;
            hi_err_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_byte_q  <= 8'h00;
            out_err_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            hi_nib_q    <= hi_nib_d;
            hi_err_q    <= hi_err_d;
            out_valid_q <= out_valid_d;
            out_byte_q  <= out_byte_d;
            out_err_q   <= out_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_byte  = out_byte_q;
    assign out_err   = out_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_hamming_byte_assembler.sv
// Bench for hamming_byte_assembler: a directed vector table, hand-written corner sequences,
// and random traffic checked against a nibble-pairing reference model.
module tb_hamming_byte_assembler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_w = 4'h0;
    logic [2:0] in_s = 3'b000;
    logic       out_ready = 1'b0;
    logic       clr_count = 1'b0;

    logic       in_ready, out_valid, out_err;
    logic [7:0] out_byte;
    logic [7:0] err_count;
    logic       in_ready2, out_valid2, out_err2;
    logic [7:0] out_byte2;
    logic [1:0] err_count2;

    hamming_byte_assembler dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_w(in_w),
        .in_s(in_s), .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
        .out_err(out_err), .clr_count(clr_count), .err_count(err_count)
    );

    hamming_byte_assembler #(.CNT_W(2)) dut_c2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_w(in_w),
        .in_s(in_s), .out_valid(out_valid2), .out_ready(out_ready), .out_byte(out_byte2),
        .out_err(out_err2), .clr_count(clr_count), .err_count(err_count2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: a pending first nibble, one output slot, and counters.
    logic       m_have_hi;
    logic [3:0] m_hi;
    logic       m_hi_err;
    logic       m_valid;
    logic [7:0] m_byte;
    logic       m_err;
    int         m_cnt8;
    int         m_cnt2;
    logic [8:0] exp_q[$];
    logic       seen_rdy;

    typedef struct {
        logic       v;
        logic [3:0] w;
        logic [2:0] s;
        logic       ordy;
        logic       rdy;
        logic       valid;
        logic [7:0] byt;
        logic       err;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_have_hi = 1'b0;
        m_hi      = 4'h0;
        m_hi_err  = 1'b0;
        m_valid   = 1'b0;
        m_byte    = 8'h00;
        m_err     = 1'b0;
        m_cnt8    = 0;
        m_cnt2    = 0;
        exp_q.delete();
    endtask

    // Entered at posedge+1 or later; asserts rst away from the edge and checks the
    // outputs change without waiting for a clock.
    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clr_count = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_byte", 32'(out_byte), 32'h0);
        chk("rst_out_err", 32'(out_err), 32'h0);
        chk("rst_err_count", 32'(err_count), 32'h0);
        chk("rst_err_count2", 32'(err_count2), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One clock cycle: drive, check ready and scoreboard before the edge, step the model, check after.
    task automatic cycle(input logic v, input logic [3:0] w, input logic [2:0] s,
                         input logic ordy, input logic clr);
        logic m_rdy, in_f, out_f;
        logic [8:0] got;
        logic [8:0] want;
        in_valid  = v;
        in_w      = w;
        in_s      = s;
        out_ready = ordy;
        clr_count = clr;
        #3;
        m_rdy = !m_have_hi || !m_valid || ordy;
        seen_rdy = in_ready;
        chk("in_ready", 32'(in_ready), 32'(m_rdy));
        chk("in_ready_c2", 32'(in_ready2), 32'(m_rdy));
        in_f  = v && m_rdy;
        out_f = m_valid && ordy;
        if (out_f) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow actual=%0h required=none at %0t", {out_err, out_byte}, $time);
            end else begin
                want = exp_q.pop_front();
                got  = {out_err, out_byte};
                chk("sb_byte", 32'(got), 32'(want));
            end
        end
        @(posedge clk);
        if (out_f) m_valid = 1'b0;
        if (in_f) begin
            if (!m_have_hi) begin
                m_have_hi = 1'b1;
                m_hi      = w;
                m_hi_err  = (s != 3'b000);
            end else begin
                m_have_hi = 1'b0;
                m_byte    = {m_hi, w};
                m_err     = m_hi_err || (s != 3'b000);
                m_valid   = 1'b1;
                exp_q.push_back({m_err, m_byte});
            end
        end
        if (clr) begin
            m_cnt8 = 0;
            m_cnt2 = 0;
        end else if (in_f && s != 3'b000) begin
            m_cnt8 = (m_cnt8 + 1 > 255) ? 255 : m_cnt8 + 1;
            m_cnt2 = (m_cnt2 + 1 > 3) ? 3 : m_cnt2 + 1;
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_byte", 32'(out_byte), 32'(m_byte));
        chk("out_err", 32'(out_err), 32'(m_err));
        chk("err_count", 32'(err_count), 32'(m_cnt8));
        chk("err_count_c2", 32'(err_count2), 32'(m_cnt2));
        chk("c2_outputs", 32'({out_valid2, out_err2, out_byte2}), 32'({m_valid, m_err, m_byte}));
    endtask

    function automatic vec_t mk(input logic v, input logic [3:0] w, input logic [2:0] s,
                                input logic ordy, input logic rdy, input logic valid,
                                input logic [7:0] byt, input logic err, input logic [7:0] cnt);
        vec_t r;
        r.v = v; r.w = w; r.s = s; r.ordy = ordy; r.rdy = rdy;
        r.valid = valid; r.byt = byt; r.err = err; r.cnt = cnt;
        return r;
    endfunction

    initial begin
        // Clean stream, erroring stream, then output stall with a back-pressured 4th nibble.
        tbl.push_back(mk(1'b1, 4'hA, 3'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0));
        tbl.push_back(mk(1'b1, 4'h5, 3'd0, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 8'd0));
        tbl.push_back(mk(1'b1, 4'h3, 3'd0, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 8'd0));
        tbl.push_back(mk(1'b1, 4'hC, 3'd0, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0, 8'd0));
        tbl.push_back(mk(1'b1, 4'h1, 3'd5, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 8'd1));
        tbl.push_back(mk(1'b1, 4'h2, 3'd0, 1'b1, 1'b1, 1'b1, 8'h12, 1'b1, 8'd1));
        tbl.push_back(mk(1'b1, 4'h4, 3'd0, 1'b1, 1'b1, 1'b0, 8'h12, 1'b1, 8'd1));
        tbl.push_back(mk(1'b1, 4'h8, 3'd2, 1'b1, 1'b1, 1'b1, 8'h48, 1'b1, 8'd2));
        tbl.push_back(mk(1'b0, 4'h0, 3'd0, 1'b1, 1'b1, 1'b0, 8'h48, 1'b1, 8'd2));
        tbl.push_back(mk(1'b1, 4'hF, 3'd0, 1'b0, 1'b1, 1'b0, 8'h48, 1'b1, 8'd2));
        tbl.push_back(mk(1'b1, 4'h0, 3'd0, 1'b0, 1'b1, 1'b1, 8'hF0, 1'b0, 8'd2));
        tbl.push_back(mk(1'b1, 4'h7, 3'd0, 1'b0, 1'b1, 1'b1, 8'hF0, 1'b0, 8'd2));
        tbl.push_back(mk(1'b1, 4'h9, 3'd0, 1'b0, 1'b0, 1'b1, 8'hF0, 1'b0, 8'd2));
        tbl.push_back(mk(1'b1, 4'h9, 3'd0, 1'b1, 1'b1, 1'b1, 8'h79, 1'b0, 8'd2));
        tbl.push_back(mk(1'b0, 4'h0, 3'd0, 1'b1, 1'b1, 1'b0, 8'h79, 1'b0, 8'd2));

        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        foreach (tbl[i]) begin
            cycle(tbl[i].v, tbl[i].w, tbl[i].s, tbl[i].ordy, 1'b0);
            chk($sformatf("tbl%0d_rdy", i), 32'(seen_rdy), 32'(tbl[i].rdy));
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].valid));
            chk($sformatf("tbl%0d_byte", i), 32'(out_byte), 32'(tbl[i].byt));
            chk($sformatf("tbl%0d_err", i), 32'(out_err), 32'(tbl[i].err));
            chk($sformatf("tbl%0d_cnt", i), 32'(err_count), 32'(tbl[i].cnt));
        end

        // Saturation of the 2-bit counter, then clear colliding with an increment.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 4'(i), 3'b111, 1'b1, 1'b0);
            chk("sat_c2", 32'(err_count2), (i < 3) ? 32'(i + 1) : 32'd3);
            chk("sat_c8", 32'(err_count), 32'(i + 1));
        end
        cycle(1'b1, 4'h6, 3'b111, 1'b1, 1'b1);
        chk("clr_c2", 32'(err_count2), 32'd0);
        chk("clr_c8", 32'(err_count), 32'd0);

        // 8-bit counter saturation.
        for (int i = 0; i < 260; i++) cycle(1'b1, 4'(i), 3'b001, 1'b1, 1'b0);
        chk("sat8_final", 32'(err_count), 32'd255);

        // Asynchronous reset mid-byte discards the held nibble and a stalled byte.
        do_reset();
        cycle(1'b1, 4'h1, 3'd0, 1'b0, 1'b0);
        cycle(1'b1, 4'h2, 3'd3, 1'b0, 1'b0);
        cycle(1'b1, 4'hB, 3'd0, 1'b0, 1'b0);
        #2;
        do_reset();
        cycle(1'b1, 4'h6, 3'd0, 1'b1, 1'b0);
        cycle(1'b1, 4'h6, 3'd0, 1'b1, 1'b0);
        chk("post_rst_byte", 32'(out_byte), 32'h66);
        chk("post_rst_valid", 32'(out_valid), 32'h1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
